// File: rtl/spi_byte_engine_if.sv
// Control and pin bundle for the SPI byte engine: decoder-side request/result
// signals plus the SPI pins. The engine takes the master view.
interface spi_byte_engine_if #(
  parameter int DIVW = 4
);
  logic            start;
  logic [7:0]      txd;
  logic [DIVW-1:0] div;
  logic [1:0]      ssel_n;
  logic            keepss;
  logic            busy;
  logic            done;
  logic [7:0]      rxd;
  logic            sck;
  logic            mosi;
  logic            miso;
  logic [1:0]      nss;

  modport master (
    input  start, txd, div, ssel_n, keepss, miso,
    output busy, done, rxd, sck, mosi, nss
  );

  modport slave (
    output start, txd, div, ssel_n, keepss, miso,
    input  busy, done, rxd, sck, mosi, nss
  );
endinterface

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter: 8 bits out on MOSI, 8 in from MISO, RXD + DONE pulse.
// A byte takes 17*(DIV+1) busy cycles; START is ignored while busy (no queueing).
module spi_byte_engine #(
  parameter int DIVW = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  spi_byte_engine_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  state_e          state_q,  state_d;
  logic [DIVW-1:0] phase_q,  phase_d;
  logic [DIVW-1:0] div_q,    div_d;
  logic [7:0]      shreg_q,  shreg_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic            rxbit_q,  rxbit_d;
  logic            keep_q,   keep_d;
  logic            sck_q,    sck_d;
  logic            mosi_q,   mosi_d;
  logic [1:0]      nss_q,    nss_d;
  logic [7:0]      rxd_q,    rxd_d;
  logic            done_q,   done_d;
  logic            phase_end;

  assign phase_end = (phase_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      div_q    <= '0;
      shreg_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      rxbit_q  <= 1'b0;
      keep_q   <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      nss_q    <= 2'b11;
      rxd_q    <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      rxbit_q  <= rxbit_d;
      keep_q   <= keep_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      nss_q    <= nss_d;
      rxd_q    <= rxd_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    div_d    = div_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    rxbit_d  = rxbit_q;
    keep_d   = keep_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    nss_d    = nss_q;
    rxd_d    = rxd_q;
    done_d   = 1'b0;

    // Every non-idle phase is div_q+1 cycles; reload happens on each transition.
    if (state_q != S_IDLE && !phase_end) begin
      phase_d = phase_q - DIVW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d  = bus.txd;
          div_d    = bus.div;
          keep_d   = bus.keepss;
          nss_d    = bus.ssel_n;
          mosi_d   = bus.txd[7];
          bitcnt_d = 3'd0;
          phase_d  = bus.div;
          state_d  = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (phase_end) begin
          sck_d   = 1'b1;
          rxbit_d = bus.miso;
          phase_d = div_q;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          sck_d   = 1'b0;
          shreg_d = {shreg_q[6:0], rxbit_q};
          phase_d = div_q;
          if (bitcnt_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            mosi_d   = shreg_q[6];
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = S_LOW;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          rxd_d   = shreg_q;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          // A burst keeps the chip selected so the next byte's START can follow glitch-free.
          if (!keep_q) begin
            nss_d = 2'b11;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.sck  = sck_q;
  assign bus.mosi = mosi_q;
  assign bus.nss  = nss_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.rxd  = rxd_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: loopback, constant and model-slave MISO sources.
module tb_spi_byte_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_byte_engine_if #(.DIVW(4)) bus ();

  spi_byte_engine #(.DIVW(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int         miso_mode = 1;
  logic       miso_const = 1'b0;
  logic [7:0] slave_byte = 8'h96;
  int         fall_cnt = 0;
  int         slave_base = 0;
  logic       slave_bit;

  always @(negedge bus.sck) fall_cnt++;
  assign slave_bit = slave_byte[3'(7 - (fall_cnt - slave_base))];
  assign bus.miso  = (miso_mode == 1) ? bus.mosi :
                     (miso_mode == 2) ? slave_bit : miso_const;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge of the DONE cycle.
  task automatic run_xfer(input string tag, input logic [7:0] txd, input logic [3:0] div,
                          input logic [1:0] ssel, input logic keep, input int extra_at,
                          input logic [7:0] exp_rx, input logic [7:0] exp_mosi);
    int cyc = 0, runs = 0, run_len = 0, bad_run = 0, nss_bad = 0, done_busy = 0, d1;
    logic prev_sck = 1'b0;
    logic [7:0] bits = 8'h00;
    d1 = int'(div) + 1;
    bus.start  = 1'b1;
    bus.txd    = txd;
    bus.div    = div;
    bus.ssel_n = ssel;
    bus.keepss = keep;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && cyc < 1000) begin
      cyc++;
      if (bus.nss !== ssel) nss_bad++;
      if (bus.done !== 1'b0) done_busy++;
      if (bus.sck === 1'b1 && prev_sck === 1'b0) bits = {bits[6:0], bus.mosi};
      if (cyc > 1 && bus.sck !== prev_sck) begin
        runs++;
        if (run_len != d1) bad_run++;
        run_len = 0;
      end
      run_len++;
      prev_sck = bus.sck;
      if (cyc == extra_at) begin
        bus.start  = 1'b1;
        bus.txd    = 8'h00;
        bus.div    = 4'd0;
        bus.ssel_n = 2'b11;
        bus.keepss = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    runs++;
    if (run_len != d1) bad_run++;
    chk({tag, " busy_cycles"}, cyc, 17 * d1);
    chk({tag, " sck_phases"}, runs, 17);
    chk({tag, " bad_phase_len"}, bad_run, 0);
    chk({tag, " mosi_bits"}, bits, exp_mosi);
    chk({tag, " nss_during_busy"}, nss_bad, 0);
    chk({tag, " done_while_busy"}, done_busy, 0);
    chk({tag, " done_pulse"}, bus.done, 1'b1);
    chk({tag, " rxd"}, bus.rxd, exp_rx);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, rises, dseen;
    logic prev_s;

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.txd    = 8'h00;
    bus.div    = 4'd0;
    bus.ssel_n = 2'b11;
    bus.keepss = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst sck", bus.sck, 1'b0);
    chk("rst mosi", bus.mosi, 1'b0);
    chk("rst nss", bus.nss, 2'b11);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst rxd", bus.rxd, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: DIV=0 loopback
    miso_mode = 1;
    run_xfer("T1", 8'hA5, 4'd0, 2'b10, 1'b0, -1, 8'hA5, 8'hA5);
    chk("T1 nss_after", bus.nss, 2'b11);
    chk("T1 mosi_after", bus.mosi, 1'b0);
    @(negedge clk);
    chk("T1 done_one_cycle", bus.done, 1'b0);
    chk("T1 rxd_held", bus.rxd, 8'hA5);

    // T2: DIV=3, MISO stuck high
    miso_mode  = 0;
    miso_const = 1'b1;
    run_xfer("T2", 8'h3C, 4'd3, 2'b01, 1'b0, -1, 8'hFF, 8'h3C);
    @(negedge clk);

    // T3: second START mid-transfer is ignored
    miso_mode = 1;
    run_xfer("T3", 8'h5A, 4'd2, 2'b10, 1'b0, 5, 8'h5A, 8'h5A);
    @(negedge clk);
    chk("T3 idle_after", bus.busy, 1'b0);

    // T4: KEEPSS burst, second START in the DONE cycle
    run_xfer("T4a", 8'h12, 4'd0, 2'b01, 1'b1, -1, 8'h12, 8'h12);
    chk("T4a nss_held", bus.nss, 2'b01);
    run_xfer("T4b", 8'h34, 4'd0, 2'b01, 1'b1, -1, 8'h34, 8'h34);
    chk("T4b nss_held", bus.nss, 2'b01);
    @(negedge clk);
    run_xfer("T4c", 8'h55, 4'd0, 2'b11, 1'b0, -1, 8'h55, 8'h55);
    chk("T4c nss_released", bus.nss, 2'b11);
    @(negedge clk);

    // T5: reset during the 4th HIGH phase
    bus.start  = 1'b1;
    bus.txd    = 8'hF0;
    bus.div    = 4'd1;
    bus.ssel_n = 2'b10;
    bus.keepss = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc    = 0;
    rises  = 0;
    prev_s = 1'b0;
    while (rises < 4 && cyc < 200) begin
      if (bus.sck === 1'b1 && prev_s === 1'b0) rises++;
      prev_s = bus.sck;
      if (rises < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("T5 in_4th_high", bus.sck, 1'b1);
    chk("T5 nss_before_reset", bus.nss, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("T5 rst sck", bus.sck, 1'b0);
    chk("T5 rst nss", bus.nss, 2'b11);
    chk("T5 rst busy", bus.busy, 1'b0);
    chk("T5 rst rxd", bus.rxd, 8'h00);
    chk("T5 rst mosi", bus.mosi, 1'b0);
    chk("T5 rst done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) dseen++;
    end
    chk("T5 quiet_after_reset", dseen, 0);
    run_xfer("T5b", 8'hC3, 4'd0, 2'b10, 1'b0, -1, 8'hC3, 8'hC3);
    @(negedge clk);

    // T6: maximum divider, model slave returns 0x96
    miso_mode  = 2;
    slave_byte = 8'h96;
    slave_base = fall_cnt;
    run_xfer("T6", 8'h0F, 4'd15, 2'b01, 1'b0, -1, 8'h96, 8'h0F);
    chk("T6 nss_after", bus.nss, 2'b11);
    @(negedge clk);
    chk("T6 done_one_cycle", bus.done, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
